// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_pkg
// Brief    : Shared types and default constants for the shared-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    // Default number of requesting cores.
    localparam int NUM_CPU_DEF      = 4;
    // Default maximum number of consecutive cycles a single grant may last.
    localparam int ARB_MAX_HOLD_DEF = 16;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_rr_picker
// Brief    : Combinational rotate-priority search. Finds the first set bit of
//            req at or after index ptr, wrapping modulo NUM_CPU.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr_picker #(
    parameter int NUM_CPU = 4
) (
    input  logic [NUM_CPU-1:0]         req,
    input  logic [$clog2(NUM_CPU)-1:0] ptr,
    output logic [NUM_CPU-1:0]         win_onehot,
    output logic [$clog2(NUM_CPU)-1:0] win_idx,
    output logic                       found
);

    localparam int IDX_W = $clog2(NUM_CPU);

    int scan_idx;

    // Walk the request vector starting at ptr; the first hit wins.
    always_comb begin
        found      = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        scan_idx   = 0;
        for (int k = 0; k < NUM_CPU; k++) begin
            scan_idx = (int'(ptr) + k) % NUM_CPU;
            if (!found && req[IDX_W'(scan_idx)]) begin
                found   = 1'b1;
                win_idx = IDX_W'(scan_idx);
            end
        end
        if (found) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Round-robin arbiter for the shared memory bus. Grants one core at
//            a time, holds the grant while its request stays high (bounded by
//            MAX_HOLD cycles), and inserts one dead cycle between owners.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_CPU  = NUM_CPU_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CPU-1:0]         req_arb,
    output logic [NUM_CPU-1:0]         gnt_arb,
    output logic [$clog2(NUM_CPU)-1:0] gnt_id,
    output logic                       bus_busy,
    output logic                       timeout_err
);

    localparam int ID_W   = $clog2(NUM_CPU);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    // Counter value at which the current grant has lasted MAX_HOLD cycles.
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};
    localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(NUM_CPU - 1);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     ptr_q,   ptr_d;
    logic [HOLD_W-1:0]   hold_q,  hold_d;
    logic [NUM_CPU-1:0]  gnt_q,   gnt_d;
    logic [ID_W-1:0]     id_q,    id_d;
    logic                busy_q,  busy_d;
    logic                tmo_q,   tmo_d;

    logic [NUM_CPU-1:0]  pick_onehot;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_found;

    bus_arbiter_rr_picker #(
        .NUM_CPU    (NUM_CPU)
    ) u_rr_picker (
        .req        (req_arb),
        .ptr        (ptr_q),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .found      (pick_found)
    );

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        busy_d  = busy_q;
        tmo_d   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_onehot;
                    id_d    = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    // Move priority past the winner so it goes to the back of the line.
                    ptr_d   = (pick_idx == LAST_ID) ? '0 : pick_idx + ID_W'(1);
                    state_d = ARB_GRANT;
                end
            end

            ARB_GRANT: begin
                hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
                // A voluntary release wins over a timeout on the same edge.
                if (!req_arb[id_q]) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ARB_RELEASE;
                end else if (hold_q == HOLD_LIMIT) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ARB_RELEASE;
                end
            end

            ARB_RELEASE: begin
                // Single turnaround cycle with the bus undriven.
                state_d = ARB_IDLE;
            end

            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt_arb     = gnt_q;
    assign gnt_id      = id_q;
    assign bus_busy    = busy_q;
    assign timeout_err = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Self-checking bench for bus_arbiter: directed scenarios with
//            literal expectations plus randomized requests against a
//            cycle-level behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int NUM_CPU  = 4;
    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_arb;
    logic [3:0] gnt_arb;
    logic [1:0] gnt_id;
    logic       bus_busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who owns the bus, for how long, dead cycles left, pointer.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_dead  = 0;
    int   m_ptr   = 0;
    logic m_tmo   = 1'b0;
    logic [3:0] exp_gnt;

    bus_arbiter #(
        .NUM_CPU     (NUM_CPU),
        .MAX_HOLD    (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_arb     (req_arb),
        .gnt_arb     (gnt_arb),
        .gnt_id      (gnt_id),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: one step per clock edge, using the request vector seen at that edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner = -1;
            m_held  = 0;
            m_dead  = 0;
            m_ptr   = 0;
            m_tmo   = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner >= 0) begin
                m_held++;
                if (!req_arb[m_owner]) begin
                    m_owner = -1;
                    m_dead  = 1;
                end else if (m_held == MAX_HOLD) begin
                    m_owner = -1;
                    m_dead  = 1;
                    m_tmo   = 1'b1;
                end
            end else if (m_dead > 0) begin
                m_dead--;
            end else begin
                for (int k = 0; k < NUM_CPU; k++) begin
                    if (m_owner < 0 && req_arb[(m_ptr + k) % NUM_CPU]) begin
                        m_owner = (m_ptr + k) % NUM_CPU;
                        m_ptr   = (m_owner + 1) % NUM_CPU;
                        m_held  = 0;
                    end
                end
            end
        end
    end

    // Compare DUT outputs to the model shortly after every rising edge.
    always @(posedge clk) begin
        #2;
        exp_gnt = '0;
        if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
        chk("cmp_gnt",  32'(gnt_arb),     32'(exp_gnt));
        chk("cmp_busy", 32'(bus_busy),    (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("cmp_tmo",  32'(timeout_err), 32'(m_tmo));
        if (m_owner >= 0) chk("cmp_id", 32'(gnt_id), m_owner);
    end

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        req_arb = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    int   n;
    int   rr_id [5];
    int   rr_t  [5];
    int   rr_exp[5] = '{0, 1, 2, 3, 0};
    logic [3:0] to_g[19];
    logic       to_t[19];
    int   cnt;
    int   found;
    int   g0;

    initial begin
        // Reset with all cores requesting: everything stays at zero.
        rst     = 1'b0;
        req_arb = 4'b1111;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gnt",  32'(gnt_arb),     32'h0);
        chk("rst_busy", 32'(bus_busy),    32'h0);
        chk("rst_tmo",  32'(timeout_err), 32'h0);
        chk("rst_id",   32'(gnt_id),      32'h0);
        @(negedge clk);
        rst     = 1'b1;
        req_arb = 4'b0001;
        @(posedge clk);
        #2;
        chk("first_gnt",  32'(gnt_arb),  32'h1);
        chk("first_id",   32'(gnt_id),   32'h0);
        chk("first_busy", 32'(bus_busy), 32'h1);

        // Round-robin: all request, each owner drops as soon as it sees its grant.
        do_reset();
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            req_arb = 4'b1111 & ~gnt_arb;
            @(posedge clk);
            #2;
            if (bus_busy && n < 5) begin
                rr_id[n] = int'(gnt_id);
                rr_t[n]  = cyc;
                n++;
            end
            @(negedge clk);
        end
        chk("rr_count", n, 5);
        for (int i = 0; i < 5; i++) chk("rr_order", rr_id[i], rr_exp[i]);
        for (int i = 1; i < 5; i++) chk("rr_spacing", rr_t[i] - rr_t[i-1], 3);

        // Timeout: core 2 requests alone and continuously.
        do_reset();
        req_arb = 4'b0100;
        for (int s = 0; s < 19; s++) begin
            @(posedge clk);
            #2;
            to_g[s] = gnt_arb;
            to_t[s] = timeout_err;
        end
        cnt = 0;
        for (int s = 0; s < 16; s++) if (to_g[s] == 4'b0100) cnt++;
        chk("to_len", cnt, 16);
        chk("to_tmo_early", 32'(to_t[15]), 32'h0);
        chk("to_drop", 32'(to_g[16]), 32'h0);
        chk("to_pulse", 32'(to_t[16]), 32'h1);
        chk("to_gap", 32'(to_g[17]), 32'h0);
        chk("to_regrant", 32'(to_g[18]), 32'h4);
        cnt = 0;
        for (int s = 0; s < 19; s++) if (to_t[s]) cnt++;
        chk("to_pulse_count", cnt, 1);

        // Pointer order: core 1 owns while 0 and 3 wait; 3 must win next.
        do_reset();
        req_arb = 4'b0010;
        @(posedge clk);
        #2;
        chk("pre_own1", 32'(gnt_arb), 32'h2);
        @(negedge clk);
        req_arb = 4'b1011;
        repeat (2) @(negedge clk);
        req_arb = 4'b1001;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #2;
            if (bus_busy) begin
                found = 1;
                break;
            end
        end
        chk("pre_found", found, 1);
        chk("pre_id", 32'(gnt_id), 32'h3);
        chk("pre_gnt", 32'(gnt_arb), 32'h8);

        // Asynchronous reset between edges while core 3 owns the bus.
        #1;
        rst = 1'b0;
        #1;
        chk("arst_gnt",  32'(gnt_arb),     32'h0);
        chk("arst_busy", 32'(bus_busy),    32'h0);
        chk("arst_tmo",  32'(timeout_err), 32'h0);
        @(posedge clk);
        #2;
        chk("arst_tmo_after", 32'(timeout_err), 32'h0);

        // Withdrawn request: core 0 pulses only during the release cycle.
        @(negedge clk);
        rst     = 1'b1;
        req_arb = 4'b0010;
        @(posedge clk);
        #2;
        chk("wd_own1", 32'(gnt_arb), 32'h2);
        @(negedge clk);
        req_arb = 4'b0000;
        @(negedge clk);
        req_arb = 4'b0001;
        @(negedge clk);
        req_arb = 4'b0000;
        cnt = 0;
        g0  = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #2;
            if (bus_busy) cnt++;
            if (gnt_arb[0]) g0++;
        end
        chk("wd_busy", cnt, 0);
        chk("wd_core0", g0, 0);

        // Randomized requests checked cycle-by-cycle by the model.
        do_reset();
        req_arb = 4'($urandom_range(0, 15));
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int b = 0; b < NUM_CPU; b++) begin
                if ($urandom_range(0, 11) == 0) req_arb[b] = ~req_arb[b];
            end
            if (i == 300) begin
                #3 rst = 1'b0;
                #1 rst = 1'b1;
            end
        end
        repeat (2) @(posedge clk);
        #3;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared memory bus behind the per-core caches. Each core's cache raises `req_arb` when it needs the bus and waits for `gnt_arb`; this block answers those requests, granting exactly one core at a time. Each grant is held while that core's request stays high, up to a hold limit. It sits at the top level of the multicore design, between the `cpu` instances and the shared memory.

## Interface
Parameters:
- `NUM_CPU`, 4: number of requesting cores; must be 2 or more.
- `MAX_HOLD`, 16: maximum consecutive cycles one grant may be held; must be 1 or more.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_arb`  in  NUM_CPU  per-core bus request; bit i comes from core i.
- `gnt_arb`  out  NUM_CPU  per-core grant; one-hot or zero, registered.
- `gnt_id`  out  $clog2(NUM_CPU)  index of the current owner; only meaningful while `bus_busy` is high.
- `bus_busy`  out  1  high while any grant is asserted.
- `timeout_err`  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- State machine states: ARB_IDLE, ARB_GRANT, ARB_RELEASE.
- **ARB_IDLE**
  - If any `req_arb` bit is high, pick the first requester at or after priority pointer `ptr`, scanning upward and wrapping modulo NUM_CPU.
  - Load `gnt_arb`/`gnt_id`, set `ptr` to winner+1 mod NUM_CPU, clear the hold counter, go to ARB_GRANT.
  - Otherwise stay in ARB_IDLE.
- **ARB_GRANT**
  - The hold counter increments every cycle.
  - If the owner's `req_arb` bit is low: clear `gnt_arb`, go to ARB_RELEASE.
  - Else if the hold counter reaches MAX_HOLD-1: clear `gnt_arb`, pulse `timeout_err`, go to ARB_RELEASE (forced revoke).
  - Requests from non-owners are ignored; they stay pending.
- **ARB_RELEASE**
  - One dead cycle with no grant, then ARB_IDLE unconditionally.
  - This guarantees bus turnaround between owners.
- Fairness: because `ptr` advances past the winner, every continuously requesting core is granted within NUM_CPU grants.
- Hold counter width: $clog2(MAX_HOLD+1). It saturates and never wraps.
- `bus_busy` equals the OR of `gnt_arb`, registered together with it.
- Reset value of every output and register: `gnt_arb`=0, `gnt_id`=0, `bus_busy`=0, `timeout_err`=0, `ptr`=0, state ARB_IDLE, hold counter 0.

## Timing
- Request-to-grant latency is 1 cycle from ARB_IDLE: request sampled high at edge t, grant visible after edge t+1... specifically, the grant is registered at edge t and visible in the following cycle.
- Release: owner request sampled low at edge t makes grant 0 after edge t. ARB_RELEASE lasts edge t to t+1, and the earliest next grant is after edge t+2. Minimum gap between two grants is 2 cycles.
- Maximum grant length is MAX_HOLD cycles. `timeout_err` is high for exactly the one cycle following the revoking edge.
- Simultaneous requests are resolved purely by `ptr` order.
- A request that drops during ARB_RELEASE or ARB_IDLE before being sampled is never granted; no request memory exists.
- Reset asserted mid-grant clears `gnt_arb` asynchronously, immediately, with no `timeout_err` pulse. After deassertion, arbitration restarts from `ptr`=0.
- A core must hold `req_arb` high until granted; dropping it early is legal and simply withdraws the request.

## Structure
- Shared package `pkg`:
  - `arb_state_t` enum with ARB_IDLE, ARB_GRANT, ARB_RELEASE.
  - Default constants `NUM_CPU_DEF`=4 and `ARB_MAX_HOLD_DEF`=16.
- Sub-module `rr_picker`: combinational rotate-priority search. Inputs are req vector and `ptr`; outputs are a one-hot winner, the winner index, and a `found` flag. The arbiter FSM registers its outputs.

## Test plan
- Reset: hold `rst`=0 with `req_arb`=4'b1111 → all outputs 0. Release reset with req 4'b0001 → `gnt_arb`=4'b0001, `gnt_id`=0 one cycle after the first sampling edge.
- Round-robin: `req_arb`=4'b1111 held, every owner drops its request one cycle after being granted → grant order 0,1,2,3,0 with a 2-cycle gap between grants.
- Timeout: MAX_HOLD=16, core 2 requests continuously alone → `gnt_arb`=4'b0100 for exactly 16 cycles, then `timeout_err` pulses once and the grant drops for 2 cycles. Core 2 is then regranted.
- Preemption order: core 1 owns the bus while cores 0 and 3 request → after core 1 releases, core 3 is granted before core 0 (`ptr`=2).
- Async reset mid-grant: assert `rst`=0 between clock edges while core 3 is granted → `gnt_arb` goes to 0 without waiting for an edge and `timeout_err` stays 0.
- Withdrawn request: core 0 pulses req for 1 cycle during ARB_RELEASE only → no grant ever issued to core 0 and `bus_busy` stays 0 afterward.
